guess_entry: RTL and testbench
==============================

Name: guess_entry

Overview:
- Player-side producer for the LED display path. Turns single-cycle button pulses into the four-slot colour guess, the cursor position and the blink enable.
- Hands each completed guess to the scorer over a valid/ready handshake. On acceptance, copies the guess into the history registers.
- All colour outputs feed the LED driver's guess/history inputs directly. blink_led/blink_enable drive its cursor blink.

Parameters:
- NUM_COLORS, 6, number of selectable colours. Codes 1..NUM_COLORS; 0 = slot empty/off. Legal range 1..7.
- MAX_GUESSES, 10, accepted submissions before the block locks. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- btn_left  in  1  one-cycle pulse, move cursor left
- btn_right  in  1  one-cycle pulse, move cursor right
- btn_color  in  1  one-cycle pulse, advance colour of slot under cursor
- btn_submit  in  1  one-cycle pulse, request submission
- game_over  in  1  level from scorer, game finished
- submit_ready  in  1  scorer can accept guess
- submit_valid  out  1  guess offered to scorer
- guess_rgb0..guess_rgb3  out  3 each  current guess slot colours
- history_rgb0..history_rgb3  out  3 each  last accepted guess
- blink_enable  out  1  cursor blink on
- blink_led  out  2  cursor slot index
- guess_count  out  4  accepted submissions so far
- locked  out  1  block locked, input ignored

Behaviour:
- Reset (async assert, sync release):
  - State EDIT; all guess and history slots 0; blink_led 0; guess_count 0.
  - submit_valid 0; locked 0; blink_enable 1 (decoded from state).
- Timing:
  - All inputs sampled on the rising clk edge.
  - Register updates are visible after that same edge; button-to-output latency is 1 edge.
  - All outputs registered except blink_enable/locked, which are decoded from state.
- States: EDIT, WAIT_ACK, LOCKED.
- EDIT (blink_enable=1, submit_valid=0): one action per cycle. Priority is submit > color > left/right.
  - btn_submit, all four slots nonzero: submit_valid <= 1, state <= WAIT_ACK, guess frozen.
  - btn_submit with any slot 0: ignored completely. Lower-priority buttons in the same cycle are also dropped.
  - btn_color: slot[blink_led] <= 1 if it is 0 or NUM_COLORS, else +1.
  - btn_left alone: blink_led - 1 mod 4 (0 wraps to 3).
  - btn_right alone: blink_led + 1 mod 4 (3 wraps to 0).
  - left and right together: no move.
  - game_over high: state <= LOCKED. Takes priority over every button.
- WAIT_ACK (blink_enable=0, submit_valid=1):
  - All buttons ignored; guess outputs held stable.
  - A transfer occurs on a cycle where submit_valid=1 and submit_ready=1. On that edge:
    - history slots <= guess slots; guess slots <= 0; blink_led <= 0; guess_count <= guess_count+1; submit_valid <= 0.
    - Next state is LOCKED if guess_count+1 == MAX_GUESSES or game_over=1, else EDIT.
  - submit_ready low: hold indefinitely; submit_valid stays 1.
  - game_over rising while waiting does not drop valid. The transfer completes first, then LOCKED.
- LOCKED (blink_enable=0, locked=1, submit_valid=0):
  - All inputs ignored; guess/history/count held.
  - Exit only via rst_n.
- Reset mid-operation (any state, including WAIT_ACK with valid high): immediate return to reset values. No partial transfer.
- guess_count never exceeds MAX_GUESSES; no wrap.

Test Plan:
- Reset, then btn_right x5 -> blink_led sequence 1,2,3,0,1. Then btn_left x2 -> 0,3. blink_enable=1 throughout.
- Cursor at 2: btn_color x7 with NUM_COLORS=6 -> guess_rgb2 = 1,2,3,4,5,6,1. Other slots remain 0.
- Slot 3 = 0, btn_submit -> submit_valid stays 0, state EDIT. Fill all slots with 1,2,3,4, submit -> submit_valid=1 next edge, blink_enable=0.
- In WAIT_ACK:
  - hold submit_ready=0 for 5 cycles while pulsing all buttons -> outputs unchanged;
  - then ready=1 -> history = 1,2,3,4, guess = 0,0,0,0, guess_count=1, blink_led=0, back to EDIT.
- MAX_GUESSES=2: complete 2 transfers -> locked=1, blink_enable=0. Further button pulses change nothing.
- Assert rst_n=0 asynchronously mid-WAIT_ACK (between edges) -> submit_valid, history, and guess_count all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/guess_entry.sv
// Player guess entry: cursor/colour editing, valid/ready submission to the scorer,
// and history capture of each accepted guess.
module guess_entry #(
  parameter int unsigned NUM_COLORS  = 6,
  parameter int unsigned MAX_GUESSES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_color,
  input  logic       btn_submit,
  input  logic       game_over,
  input  logic       submit_ready,
  output logic       submit_valid,
  output logic [2:0] guess_rgb0,
  output logic [2:0] guess_rgb1,
  output logic [2:0] guess_rgb2,
  output logic [2:0] guess_rgb3,
  output logic [2:0] history_rgb0,
  output logic [2:0] history_rgb1,
  output logic [2:0] history_rgb2,
  output logic [2:0] history_rgb3,
  output logic       blink_enable,
  output logic [1:0] blink_led,
  output logic [3:0] guess_count,
  output logic       locked
);

  typedef enum logic [1:0] {
    EDIT     = 2'd0,
    WAIT_ACK = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_COLOR = 3'(NUM_COLORS);
  localparam logic [3:0] LAST_GUESS = 4'(MAX_GUESSES);

  state_t     state;
  logic [2:0] guess   [4];
  logic [2:0] history [4];
  logic       all_filled;

  function automatic logic [2:0] next_color(input logic [2:0] c);
    return ((c == 3'd0) || (c == LAST_COLOR)) ? 3'd1 : c + 3'd1;
  endfunction

  always_comb begin
    all_filled = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (guess[i] == 3'd0) all_filled = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EDIT;
      submit_valid <= 1'b0;
      blink_led    <= '0;
      guess_count  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        guess[i]   <= '0;
        history[i] <= '0;
      end
    end else begin
      case (state)
        EDIT: begin
          if (game_over) begin
            state <= LOCKED;
          end else if (btn_submit) begin
            // An incomplete submit still consumes the cycle: other buttons are dropped.
            if (all_filled) begin
              submit_valid <= 1'b1;
              state        <= WAIT_ACK;
            end
          end else if (btn_color) begin
            guess[blink_led] <= next_color(guess[blink_led]);
          end else if (btn_left && !btn_right) begin
            blink_led <= blink_led - 2'd1;
          end else if (btn_right && !btn_left) begin
            blink_led <= blink_led + 2'd1;
          end
        end
        WAIT_ACK: begin
          if (submit_ready) begin
            for (int unsigned i = 0; i < 4; i++) begin
              history[i] <= guess[i];
              guess[i]   <= '0;
            end
            blink_led    <= '0;
            guess_count  <= guess_count + 4'd1;
            submit_valid <= 1'b0;
            state <= ((guess_count + 4'd1 == LAST_GUESS) || game_over) ? LOCKED : EDIT;
          end
        end
        default: begin
          state <= LOCKED;
        end
      endcase
    end
  end

  assign blink_enable = (state == EDIT);
  assign locked       = (state == LOCKED);

  assign guess_rgb0   = guess[0];
  assign guess_rgb1   = guess[1];
  assign guess_rgb2   = guess[2];
  assign guess_rgb3   = guess[3];
  assign history_rgb0 = history[0];
  assign history_rgb1 = history[1];
  assign history_rgb2 = history[2];
  assign history_rgb3 = history[3];

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry with NUM_COLORS=6, MAX_GUESSES=2.
module tb_guess_entry;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_color = 1'b0, btn_submit = 1'b0;
  logic       game_over = 1'b0, submit_ready = 1'b0;
  logic       submit_valid;
  logic [2:0] guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3;
  logic [2:0] history_rgb0, history_rgb1, history_rgb2, history_rgb3;
  logic       blink_enable;
  logic [1:0] blink_led;
  logic [3:0] guess_count;
  logic       locked;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  guess_entry #(.NUM_COLORS(6), .MAX_GUESSES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_color(btn_color), .btn_submit(btn_submit),
    .game_over(game_over), .submit_ready(submit_ready), .submit_valid(submit_valid),
    .guess_rgb0(guess_rgb0), .guess_rgb1(guess_rgb1), .guess_rgb2(guess_rgb2), .guess_rgb3(guess_rgb3),
    .history_rgb0(history_rgb0), .history_rgb1(history_rgb1),
    .history_rgb2(history_rgb2), .history_rgb3(history_rgb3),
    .blink_enable(blink_enable), .blink_led(blink_led), .guess_count(guess_count), .locked(locked)
  );

  always #5 clk = ~clk;

  // Drive one cycle of buttons, sample 1 time unit after the edge.
  task automatic pulse(input logic l, input logic r, input logic c, input logic s);
    btn_left = l; btn_right = r; btn_color = c; btn_submit = s;
    @(posedge clk); #1;
    btn_left = 1'b0; btn_right = 1'b0; btn_color = 1'b0; btn_submit = 1'b0;
  endtask

  // Assumes cursor at 0 and all slots empty; leaves cursor back at 0.
  task automatic fill(input int unsigned a, input int unsigned b, input int unsigned c, input int unsigned d);
    int unsigned cnt [4];
    cnt[0] = a; cnt[1] = b; cnt[2] = c; cnt[3] = d;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < int'(cnt[s]); k++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({submit_valid, locked, blink_enable, blink_led, guess_count} !== {1'b0, 1'b0, 1'b1, 2'd0, 4'd0})
      $display("FAIL reset_ctrl: got v=%b l=%b be=%b led=%0d cnt=%0d, want 0 0 1 0 0",
               submit_valid, locked, blink_enable, blink_led, guess_count);
    else n_pass++;
    n_total++;
    if ({guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3, history_rgb0, history_rgb1, history_rgb2, history_rgb3} !== 24'd0)
      $display("FAIL reset_slots: got %h, want 0",
               {guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3, history_rgb0, history_rgb1, history_rgb2, history_rgb3});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_cursor();
    logic [1:0] exp_r [5];
    logic [1:0] exp_l [2];
    exp_r[0] = 2'd1; exp_r[1] = 2'd2; exp_r[2] = 2'd3; exp_r[3] = 2'd0; exp_r[4] = 2'd1;
    exp_l[0] = 2'd0; exp_l[1] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      n_total++;
      if (blink_led !== exp_r[i] || blink_enable !== 1'b1)
        $display("FAIL cursor_right[%0d]: got led=%0d be=%b, want led=%0d be=1", i, blink_led, blink_enable, exp_r[i]);
      else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (blink_led !== exp_l[i] || blink_enable !== 1'b1)
        $display("FAIL cursor_left[%0d]: got led=%0d be=%b, want led=%0d be=1", i, blink_led, blink_enable, exp_l[i]);
      else n_pass++;
    end
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (blink_led !== 2'd3) $display("FAIL cursor_both: got led=%0d, want 3", blink_led);
    else n_pass++;
  endtask

  task automatic test_color();
    logic [2:0] exp_c [7];
    exp_c[0] = 3'd1; exp_c[1] = 3'd2; exp_c[2] = 3'd3; exp_c[3] = 3'd4;
    exp_c[4] = 3'd5; exp_c[5] = 3'd6; exp_c[6] = 3'd1;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);  // cursor 3 -> 2
    for (int i = 0; i < 7; i++) begin
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      n_total++;
      if (guess_rgb2 !== exp_c[i]) $display("FAIL color_step[%0d]: got %0d, want %0d", i, guess_rgb2, exp_c[i]);
      else n_pass++;
    end
    n_total++;
    if ({guess_rgb0, guess_rgb1, guess_rgb3} !== 9'd0)
      $display("FAIL color_others: got %0d %0d %0d, want 0 0 0", guess_rgb0, guess_rgb1, guess_rgb3);
    else n_pass++;
  endtask

  task automatic test_submit();
    // Slot 3 empty: submit with color must drop both.
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    n_total++;
    if (submit_valid !== 1'b0 || blink_enable !== 1'b1 || guess_rgb2 !== 3'd1)
      $display("FAIL submit_incomplete: got v=%b be=%b slot2=%0d, want 0 1 1", submit_valid, blink_enable, guess_rgb2);
    else n_pass++;
    pulse(1'b0, 1'b0, 1'b1, 1'b0); pulse(1'b0, 1'b0, 1'b1, 1'b0);  // slot2 = 3
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0); pulse(1'b0, 1'b0, 1'b1, 1'b0);  // slot1 = 2
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);                                  // slot0 = 1
    pulse(1'b1, 1'b0, 1'b0, 1'b0);                                  // wrap to 3
    for (int k = 0; k < 4; k++) pulse(1'b0, 1'b0, 1'b1, 1'b0);      // slot3 = 4
    n_total++;
    if ({guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3, blink_led} !== {3'd1, 3'd2, 3'd3, 3'd4, 2'd3})
      $display("FAIL fill_1234: got %0d %0d %0d %0d led=%0d, want 1 2 3 4 led=3",
               guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3, blink_led);
    else n_pass++;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (submit_valid !== 1'b1 || blink_enable !== 1'b0 || locked !== 1'b0)
      $display("FAIL submit_ok: got v=%b be=%b lk=%b, want 1 0 0", submit_valid, blink_enable, locked);
    else n_pass++;
  endtask

  task automatic test_wait_ack();
    submit_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, i[0], 1'b1, 1'b1);
      n_total++;
      if ({submit_valid, blink_enable, blink_led, guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3, guess_count}
          !== {1'b1, 1'b0, 2'd3, 3'd1, 3'd2, 3'd3, 3'd4, 4'd0})
        $display("FAIL wait_hold[%0d]: got v=%b be=%b led=%0d g=%0d%0d%0d%0d cnt=%0d, want 1 0 3 1234 0", i,
                 submit_valid, blink_enable, blink_led, guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3, guess_count);
      else n_pass++;
    end
    submit_ready = 1'b1;
    @(posedge clk); #1;
    submit_ready = 1'b0;
    n_total++;
    if ({history_rgb0, history_rgb1, history_rgb2, history_rgb3} !== {3'd1, 3'd2, 3'd3, 3'd4})
      $display("FAIL xfer_history: got %0d %0d %0d %0d, want 1 2 3 4", history_rgb0, history_rgb1, history_rgb2, history_rgb3);
    else n_pass++;
    n_total++;
    if ({guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3, guess_count, blink_led, submit_valid, blink_enable, locked}
        !== {12'd0, 4'd1, 2'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL xfer_state: got g=%0d%0d%0d%0d cnt=%0d led=%0d v=%b be=%b lk=%b, want 0000 1 0 0 1 0",
               guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3, guess_count, blink_led, submit_valid, blink_enable, locked);
    else n_pass++;
  endtask

  task automatic test_lock_max();
    fill(2, 2, 2, 2);
    submit_ready = 1'b1;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (submit_valid !== 1'b1) $display("FAIL second_valid: got %b, want 1", submit_valid);
    else n_pass++;
    @(posedge clk); #1;
    submit_ready = 1'b0;
    n_total++;
    if ({locked, blink_enable, submit_valid, guess_count} !== {1'b1, 1'b0, 1'b0, 4'd2})
      $display("FAIL lock_max: got lk=%b be=%b v=%b cnt=%0d, want 1 0 0 2", locked, blink_enable, submit_valid, guess_count);
    else n_pass++;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    submit_ready = 1'b1;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    submit_ready = 1'b0;
    n_total++;
    if ({locked, submit_valid, blink_led, guess_rgb0, guess_count, history_rgb0, history_rgb3}
        !== {1'b1, 1'b0, 2'd0, 3'd0, 4'd2, 3'd2, 3'd2})
      $display("FAIL locked_ignore: got lk=%b v=%b led=%0d g0=%0d cnt=%0d h0=%0d h3=%0d, want 1 0 0 0 2 2 2",
               locked, submit_valid, blink_led, guess_rgb0, guess_count, history_rgb0, history_rgb3);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    fill(1, 1, 1, 1);
    submit_ready = 1'b1;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    submit_ready = 1'b0;
    fill(3, 3, 3, 3);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (submit_valid !== 1'b1 || guess_count !== 4'd1 || history_rgb0 !== 3'd1)
      $display("FAIL pre_async: got v=%b cnt=%0d h0=%0d, want 1 1 1", submit_valid, guess_count, history_rgb0);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({submit_valid, guess_count, history_rgb0, history_rgb1, history_rgb2, history_rgb3, guess_rgb0} !== 20'd0)
      $display("FAIL async_reset: got v=%b cnt=%0d h=%0d%0d%0d%0d g0=%0d, want all 0",
               submit_valid, guess_count, history_rgb0, history_rgb1, history_rgb2, history_rgb3, guess_rgb0);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_game_over();
    // game_over during WAIT_ACK: transfer completes, then LOCKED.
    fill(5, 6, 1, 2);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    game_over = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (submit_valid !== 1'b1 || locked !== 1'b0)
      $display("FAIL go_wait_hold: got v=%b lk=%b, want 1 0", submit_valid, locked);
    else n_pass++;
    submit_ready = 1'b1;
    @(posedge clk); #1;
    submit_ready = 1'b0;
    n_total++;
    if ({locked, submit_valid, guess_count, history_rgb0, history_rgb1} !== {1'b1, 1'b0, 4'd1, 3'd5, 3'd6})
      $display("FAIL go_wait_lock: got lk=%b v=%b cnt=%0d h0=%0d h1=%0d, want 1 0 1 5 6",
               locked, submit_valid, guess_count, history_rgb0, history_rgb1);
    else n_pass++;
    game_over = 1'b0;
    do_reset();
    // game_over in EDIT beats a button in the same cycle.
    game_over = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    game_over = 1'b0;
    n_total++;
    if ({locked, blink_enable, guess_rgb0} !== {1'b1, 1'b0, 3'd0})
      $display("FAIL go_edit: got lk=%b be=%b g0=%0d, want 1 0 0", locked, blink_enable, guess_rgb0);
    else n_pass++;
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_cursor();
        test_color();
        test_submit();
        test_wait_ack();
        test_lock_max();
        test_async_reset();
        test_game_over();
      end
      begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget, want completion");
        $fatal(1);
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
